// File: rtl/instr_fetch.sv
// instr_fetch: ROM instruction fetcher with a valid/ready consumer handshake.
// Fetch latency is one cycle and throughput is one word per two cycles.
// Optional feature macro FETCH_WRAP_EN: when defined, the PC wraps from the
// last ROM address back to 0. When undefined, accepting the last word halts.
module instr_fetch #(
  parameter int unsigned        ADDR_W    = 3,
  parameter int unsigned        DATA_W    = 16,
  parameter logic [DATA_W-1:0]  HALT_WORD = '1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_addr,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic              halted
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    HALT  = 2'd3
  } state_e;

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
`ifndef FETCH_WRAP_EN
  localparam logic [ADDR_W-1:0] PC_LAST = '1;
`endif

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   instr_q, instr_d;
  logic [ADDR_W-1:0]   instr_addr_q, instr_addr_d;
  logic                instr_valid_q, instr_valid_d;
  logic                halted_q, halted_d;

  // The ROM is only enabled while fetching; the address always follows the PC.
  assign rom_ce      = (state_q == FETCH);
  assign rom_addr    = pc_q;
  assign instr       = instr_q;
  assign instr_addr  = instr_addr_q;
  assign instr_valid = instr_valid_q;
  assign halted      = halted_q;

  // State and datapath registers; reset drops any pending word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= '0;
      instr_q       <= '0;
      instr_addr_q  <= '0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_addr_q  <= instr_addr_d;
      instr_valid_q <= instr_valid_d;
      halted_q      <= halted_d;
    end
  end

  // Next-state logic: fetch, hold until accepted, then advance, jump or halt.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_addr_d  = instr_addr_q;
    instr_valid_d = instr_valid_q;
    halted_d      = halted_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          pc_d    = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        instr_d       = rom_data;
        instr_addr_d  = pc_q;
        instr_valid_d = 1'b1;
        state_d       = HOLD;
      end
      HOLD: begin
        // jump_en only matters on the accepting edge
        if (instr_ready) begin
          instr_valid_d = 1'b0;
          if (instr_q == HALT_WORD) begin
            halted_d = 1'b1;
            state_d  = HALT;
          end else if (jump_en) begin
            pc_d    = jump_addr;
            state_d = FETCH;
`ifdef FETCH_WRAP_EN
          end else begin
            pc_d    = pc_q + PC_ONE;
            state_d = FETCH;
          end
`else
          end else if (pc_q == PC_LAST) begin
            halted_d = 1'b1;
            state_d  = HALT;
          end else begin
            pc_d    = pc_q + PC_ONE;
            state_d = FETCH;
          end
`endif
        end
      end
      HALT: begin
        if (start) begin
          halted_d = 1'b0;
          pc_d     = '0;
          state_d  = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: stimulus pushes expected (addr, word)
// pairs, a negedge monitor pops and compares on every accepted word.
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        rom_ce;
  logic [2:0]  rom_addr;
  logic [15:0] rom_data;
  logic [15:0] instr;
  logic [2:0]  instr_addr;
  logic        instr_valid;
  logic        instr_ready;
  logic        jump_en;
  logic [2:0]  jump_addr;
  logic        halted;

  logic [15:0] rom [0:7];
  assign rom_data = rom[rom_addr];

  typedef struct packed {
    logic [2:0]  a;
    logic [15:0] d;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int passes = 0;
  int ce_cnt = 0;

  instr_fetch #(.ADDR_W(3), .DATA_W(16), .HALT_WORD(16'hFFFF)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rom_ce(rom_ce),
    .rom_addr(rom_addr), .rom_data(rom_data), .instr(instr),
    .instr_addr(instr_addr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .jump_en(jump_en), .jump_addr(jump_addr),
    .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic push_exp(input logic [2:0] a, input logic [15:0] d);
    exp_t e;
    e.a = a;
    e.d = d;
    sb.push_back(e);
  endtask

  // Monitor: count ROM enables and score every accepted word.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rom_ce) ce_cnt++;
      if (instr_valid && instr_ready) begin
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL sb_unexpected: got addr %h word %h with nothing expected", instr_addr, instr);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_addr", {29'd0, instr_addr}, {29'd0, e.a});
          chk("sb_data", {16'd0, instr}, {16'd0, e.d});
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!instr_valid && n < 20) begin
      step();
      n++;
    end
    chk(name, {31'd0, instr_valid}, 32'd1);
  endtask

  task automatic wait_halted(input string name);
    int n;
    n = 0;
    while (!halted && n < 60) begin
      step();
      n++;
    end
    chk(name, {31'd0, halted}, 32'd1);
  endtask

  task automatic accept_one();
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic load_rom();
    for (int i = 0; i < 8; i++) rom[i] = 16'h0100 + 16'(i);
    rom[5] = 16'hFFFF;
  endtask

  initial begin
    int n;
    start = 1'b0; instr_ready = 1'b0; jump_en = 1'b0; jump_addr = 3'd0;
    rst_n = 1'b0;
    load_rom();
    step();
    chk("rst_outputs", {27'd0, instr_valid, halted, rom_ce, rom_addr},  32'd0);
    chk("rst_instr", {13'd0, instr_addr, instr}, 32'd0);
    rst_n = 1'b1;
    step();

    // Straight-line run to the halt word with ready tied high.
    instr_ready = 1'b1;
    ce_cnt = 0;
    for (int i = 0; i < 5; i++) push_exp(3'(i), 16'h0100 + 16'(i));
    push_exp(3'd5, 16'hFFFF);
    pulse_start();
    wait_halted("t1_halted");
    chk("t1_after_halt", {30'd0, instr_valid, rom_ce}, 32'd0);
    chk("t1_ce_pulses", ce_cnt, 32'd6);
    chk("t1_sb_drained", sb.size(), 32'd0);

    // Stall on address 0, ignored start/jump, then jump from 1 to 4.
    instr_ready = 1'b0;
    push_exp(3'd0, 16'h0100);
    push_exp(3'd1, 16'h0101);
    push_exp(3'd4, 16'h0104);
    push_exp(3'd5, 16'hFFFF);
    pulse_start();
    chk("t2_halt_cleared", {31'd0, halted}, 32'd0);
    wait_valid("t2_valid0");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_stall", {11'd0, instr_valid, rom_ce, instr_addr, instr}, {11'd0, 1'b1, 1'b0, 3'd0, 16'h0100});
      if (i == 1) start = 1'b1;
      step();
      start = 1'b0;
    end
    accept_one();
    wait_valid("t2_valid1");
    chk("t2_addr1", {29'd0, instr_addr}, 32'd1);
    jump_en = 1'b1; jump_addr = 3'd6;
    step();
    jump_en = 1'b0;
    chk("t3_nohs_jump", {12'd0, instr_valid, instr_addr, instr}, {12'd0, 1'b1, 3'd1, 16'h0101});
    jump_en = 1'b1; jump_addr = 3'd4; instr_ready = 1'b1;
    step();
    jump_en = 1'b0;
    wait_halted("t3_halted");
    chk("t3_sb_drained", sb.size(), 32'd0);

    // End-of-ROM behaviour with no halt word in the ROM.
    rom[5] = 16'h0105;
    rom[7] = 16'h0107;
    instr_ready = 1'b1;
    for (int i = 0; i < 8; i++) push_exp(3'(i), 16'h0100 + 16'(i));
`ifdef FETCH_WRAP_EN
    push_exp(3'd0, 16'h0100);
    pulse_start();
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      step();
      n++;
    end
    instr_ready = 1'b0;
    chk("t4_wrap_drained", sb.size(), 32'd0);
    chk("t4_wrap_running", {31'd0, halted}, 32'd0);
`else
    pulse_start();
    wait_halted("t4_end_halt");
    chk("t4_sb_drained", sb.size(), 32'd0);
`endif
    instr_ready = 1'b0;
    do_reset();

    // Reset while holding the word at address 2.
    load_rom();
    push_exp(3'd0, 16'h0100);
    push_exp(3'd1, 16'h0101);
    pulse_start();
    wait_valid("t5_valid0");
    accept_one();
    wait_valid("t5_valid1");
    accept_one();
    wait_valid("t5_valid2");
    chk("t5_hold2", {13'd0, instr_addr, instr}, {13'd0, 3'd2, 16'h0102});
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_rst", {8'd0, instr_valid, halted, rom_ce, rom_addr, instr_addr, instr}, 32'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t5_idle", {30'd0, instr_valid, rom_ce}, 32'd0);
    end
    chk("t5_sb_drained", sb.size(), 32'd0);
    instr_ready = 1'b1;
    for (int i = 0; i < 5; i++) push_exp(3'(i), 16'h0100 + 16'(i));
    push_exp(3'd5, 16'hFFFF);
    pulse_start();
    wait_halted("t5_restart_halt");
    chk("t5_restart_drained", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 3, ROM address width.
REQ-002 SHALL have parameter DATA_W, default 16, ROM/instruction word width.
REQ-003 SHALL have parameter HALT_WORD, default all-ones (DATA_W bits), the fetched word that stops fetching.
REQ-004 SHALL have port clk, input, 1, single clock; all state changes on rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, one-cycle pulse that begins fetching from address 0.
REQ-007 SHALL have port rom_ce, output, 1, chip enable to ROM.
REQ-008 SHALL have port rom_addr, output, ADDR_W, address to ROM.
REQ-009 SHALL have port rom_data, input, DATA_W, combinational ROM read data.
REQ-010 SHALL have port instr, output, DATA_W, registered fetched word.
REQ-011 SHALL have port instr_addr, output, ADDR_W, address from which instr was fetched.
REQ-012 SHALL have port instr_valid, output, 1, instr/instr_addr hold a word for the consumer.
REQ-013 SHALL have port instr_ready, input, 1, consumer accepts the word.
REQ-014 SHALL have port jump_en, input, 1, redirect on acceptance.
REQ-015 SHALL have port jump_addr, input, ADDR_W, redirect target.
REQ-016 SHALL have port halted, output, 1, fetcher stopped.

Function
REQ-017 SHALL implement states IDLE, FETCH, HOLD, HALT in a registered state machine.
REQ-018 IDLE: rom_ce=0; start=1 SHALL set pc=0 and move to FETCH.
REQ-019 FETCH: rom_ce=1, rom_addr=pc combinationally; next edge SHALL latch instr<=rom_data, instr_addr<=pc, instr_valid<=1, move to HOLD (one-cycle fetch latency).
REQ-020 rom_ce SHALL be 0 and rom_addr SHALL hold pc in every state other than FETCH.
REQ-021 HOLD: instr, instr_addr, instr_valid SHALL remain stable while instr_ready=0.
REQ-022 HOLD with instr_ready=1 (handshake) SHALL clear instr_valid on that edge.
REQ-023 On handshake, instr==HALT_WORD SHALL move to HALT regardless of jump_en.
REQ-024 On handshake otherwise, SHALL set pc=jump_addr if jump_en=1, else pc+1 (wrap rule per Configuration), and move to FETCH.
REQ-025 jump_en without handshake SHALL be ignored.
REQ-026 HALT: halted=1, rom_ce=0; start=1 SHALL clear halted, set pc=0, move to FETCH.
REQ-027 start in FETCH or HOLD SHALL be ignored.
REQ-028 Sustained throughput with instr_ready tied high SHALL be one instruction per two cycles.

Reset
REQ-029 rst_n=0 SHALL asynchronously force state=IDLE, pc=0, instr=0, instr_addr=0, instr_valid=0, halted=0, rom_ce=0, rom_addr=0.
REQ-030 Reset asserted mid-FETCH or mid-HOLD SHALL discard the pending word; after release, no fetch occurs until start.

Configuration
REQ-031 Macro FETCH_WRAP_EN SHALL select end-of-ROM behaviour.
REQ-032 With FETCH_WRAP_EN defined, pc+1 from address 2^ADDR_W-1 SHALL wrap to 0 and fetching continues.
REQ-033 Without FETCH_WRAP_EN, handshake of the word at address 2^ADDR_W-1 (no jump) SHALL move to HALT with halted=1.

Verification (bench ROM: addr n holds 16'h0100+n, addr 5 holds 16'hFFFF)
REQ-034 Reset, start pulse, instr_ready=1 -> instr_addr 0..5 with instr 0100..0104 then FFFF; halted=1 one cycle after FFFF accepted; rom_ce pulses only in FETCH.
REQ-035 Start, hold instr_ready=0 for 4 cycles on addr 0 -> instr=0100, instr_valid=1 stable; rom_ce=0 during stall; next word addr 1 after ready.
REQ-036 Handshake at addr 1 with jump_en=1, jump_addr=4 -> next instr_addr=4, instr=0104; jump_en pulsed in a non-handshake cycle -> no effect.
REQ-037 ROM addr 5 replaced by 0105, addr 7 = 0107, ready=1 -> with FETCH_WRAP_EN next instr_addr=0; without it halted=1 after addr 7.
REQ-038 rst_n low during HOLD at addr 2 -> instr_valid=0, instr=0 immediately; after release, outputs stay idle until start, then fetch restarts at addr 0.
